// File: rtl/alu_arbiter_if.sv
// ============================================================================
//  Module      : alu_arbiter_if
//  Description : Requester-side bus of the two-port ALU arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_arbiter_if;
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [21:0] cmd0;
    logic [21:0] cmd1;
    logic [1:0]  ack;
    logic [7:0]  result;
    logic [3:0]  flags;
    logic        owner;
    logic        busy;

    modport master (
        output req, lock, cmd0, cmd1,
        input  ack, result, flags, owner, busy
    );

    modport slave (
        input  req, lock, cmd0, cmd1,
        output ack, result, flags, owner, busy
    );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin arbiter with bounded lock sharing one 8-bit ALU
//                between two requesters; IDLE -> EXEC -> RESP per operation.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int unsigned LOCK_MAX = 4
) (
    input  wire logic       CLK,
    input  wire logic       Reset,
    alu_arbiter_if.slave    bus,
    output logic [7:0]      ALU_arg_0,
    output logic [7:0]      ALU_arg_1,
    output logic [2:0]      ALU_op_code,
    output logic [1:0]      Data_op_code,
    output logic            Data_signifier,
    output logic            SC_IN,
    input  wire logic [7:0] ALU_out,
    input  wire logic       ZERO,
    input  wire logic       BEVEN,
    input  wire logic       PARITY,
    input  wire logic       EQUAL
);

    localparam logic [3:0] c_LOCK_MAX = 4'(LOCK_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [21:0] cmd_q, cmd_d;
    logic        owner_q, owner_d;
    logic        rr_q, rr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_lock_q, last_lock_d;
    logic [7:0]  result_q, result_d;
    logic [3:0]  flags_q, flags_d;

    logic        w_own_req;
    logic        w_oth_req;
    logic        w_cont;
    logic        w_sat;
    logic        w_rr_win;
    logic        w_win;
    logic [3:0]  w_cnt_next;
    logic        w_exec;

    // Owner keeps the ALU while its lock streak is below the bound, or past
    // the bound as long as nobody else is waiting.
    assign w_own_req  = bus.req[owner_q];
    assign w_oth_req  = bus.req[~owner_q];
    assign w_cont     = last_lock_q && w_own_req && (cnt_q < c_LOCK_MAX);
    assign w_sat      = last_lock_q && (cnt_q == c_LOCK_MAX) && w_own_req && !w_oth_req;
    assign w_rr_win   = bus.req[rr_q] ? rr_q : ~rr_q;
    assign w_win      = (w_cont || w_sat) ? owner_q : w_rr_win;
    assign w_cnt_next = w_cont ? (cnt_q + 4'd1) : (w_sat ? cnt_q : 4'd1);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            owner_q     <= 1'b0;
            rr_q        <= 1'b0;
            cnt_q       <= '0;
            last_lock_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            last_lock_q <= last_lock_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        last_lock_d = last_lock_q;
        result_d    = result_q;
        flags_d     = flags_q;
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    state_d     = S_EXEC;
                    cmd_d       = w_win ? bus.cmd1 : bus.cmd0;
                    owner_d     = w_win;
                    rr_d        = ~w_win;
                    cnt_d       = w_cnt_next;
                    last_lock_d = bus.lock[w_win];
                end
            end
            S_EXEC: begin
                result_d = ALU_out;
                flags_d  = {ZERO, BEVEN, PARITY, EQUAL};
                state_d  = S_RESP;
            end
            S_RESP: begin
                // req is deliberately not sampled here; a held stale request
                // is only reconsidered from IDLE.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign w_exec = (state_q == S_EXEC);

    assign Data_signifier = w_exec ? cmd_q[21]    : 1'b0;
    assign Data_op_code   = w_exec ? cmd_q[20:19] : 2'b00;
    assign ALU_op_code    = w_exec ? cmd_q[18:16] : 3'b000;
    assign ALU_arg_0      = w_exec ? cmd_q[15:8]  : 8'h00;
    assign ALU_arg_1      = w_exec ? cmd_q[7:0]   : 8'h00;
    assign SC_IN          = 1'b0;

    assign bus.ack    = (state_q == S_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.busy   = (state_q != S_IDLE);
    assign bus.owner  = owner_q;
    assign bus.result = result_q;
    assign bus.flags  = flags_q;

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational 8-bit ALU between two requesters, e.g. the execute stage and a multi-byte helper sequencer.
- Arbitrates round-robin, with an optional bounded lock so one requester can run back-to-back operations such as multi-byte add chains.
- Drives the ALU control and operand inputs from a registered command, then captures the ALU result and flags into a result register.
- Returns the captured result to the winner with a one-cycle ack pulse.

Parameters:
LOCK_MAX, 4, maximum consecutive grants to one owner while its lock is held (range 1..15).

Ports:
CLK  in  1  clock; all state updates on the rising edge.
Reset  in  1  asynchronous, active-high reset.
req  in  2  request per requester; held high until the matching ack.
lock  in  2  per requester: ask to keep ownership for the next operation; sampled at grant.
cmd0  in  22  requester 0 command {Data_signifier, Data_op_code[1:0], ALU_op_code[2:0], arg0[7:0], arg1[7:0]}; held stable while req[0] is high.
cmd1  in  22  requester 1 command, same format as cmd0.
ack  out  2  one-hot, one-cycle pulse: result and flags are valid for that requester.
result  out  8  captured ALU_out.
flags  out  4  captured {ZERO, BEVEN, PARITY, EQUAL}.
owner  out  1  index of the current or last granted requester.
busy  out  1  high in EXEC and RESP.
ALU_arg_0, ALU_arg_1  out  8 each  ALU operands.
ALU_op_code  out  3  ALU arithmetic opcode.
Data_op_code  out  2  ALU data opcode.
Data_signifier  out  1  selects arithmetic (0) or data (1) operation.
SC_IN  out  1  ALU carry/shift in; tied to 0.
ALU_out  in  8  ALU result.
ZERO, BEVEN, PARITY, EQUAL  in  1 each  ALU flag outputs.

Behaviour:
- Reset (async):
  - state=IDLE; ack=0, result=0, flags=0, owner=0, busy=0.
  - rr_ptr=0 (requester 0 has priority); lock_cnt=0; last_lock=0.
  - Command register cleared.
- States: IDLE -> EXEC -> RESP -> IDLE. EXEC and RESP always last exactly one cycle.
- IDLE:
  - No req: stay in IDLE.
  - Any req: pick a winner, latch its cmd, set owner=winner, go to EXEC.
- Winner selection, in priority order:
  1. Lock continuation: last_lock=1, req[owner]=1 and lock_cnt<LOCK_MAX -> owner wins, lock_cnt++.
  2. Saturated lock, no competitor: last_lock=1, lock_cnt=LOCK_MAX, req[owner]=1 and req[~owner]=0 -> owner wins; lock_cnt holds at LOCK_MAX.
  3. Otherwise round-robin: rr_ptr's requester wins if requesting, else the other one. lock_cnt=1 if the winner equals the previous owner with last_lock=1, else 1 for the new owner.
- After every grant: rr_ptr = ~winner; last_lock = lock[winner] sampled at grant.
- EXEC:
  - ALU inputs are driven from the command register.
  - At the clock edge, result<=ALU_out and flags<={ZERO,BEVEN,PARITY,EQUAL}; go to RESP.
- RESP:
  - ack[owner]=1 for exactly this cycle; go to IDLE.
  - The requester drops req or presents its next cmd in the following cycle.
  - The arbiter never samples req during RESP, so a held stale req is not double-granted.
- Outside EXEC, all ALU control and operand outputs are driven to 0.
- result and flags hold their value until the next EXEC capture.
- Latency: req seen at IDLE edge k -> ack high in cycle k+2. Throughput: 1 operation per 3 cycles.
- lock_cnt is 4 bits wide and saturates at LOCK_MAX.
- Reset mid-operation (in EXEC or RESP): the operation is abandoned, no ack is issued, all outputs return to reset values.

Test Plan:
- Single request: reset, req[0]=1, cmd0 = arithmetic kADD, arg0=8'h05, arg1=8'h03 -> EXEC one cycle later; ack=2'b01 two cycles after grant; result=8'h08; flags=4'b0100; busy high for 2 cycles.
- Simultaneous requests after reset: both req held, both lock=0 -> grant order 0,1,0,1; each ack is one-hot and one cycle long; no cycle with both ack bits set.
- Bounded lock: LOCK_MAX=4, req=2'b11, lock[0]=1, lock[1]=0 -> grant order 0,0,0,0,1,0.
- Saturated lock, no competitor: req=2'b01 only, lock[0]=1 -> requester 0 is granted on every IDLE with no stall; lock_cnt stays at 4.
- Data path command: cmd1 with Data_signifier=1 and kFLAG, arg1=8'h00 -> result=8'h06; ALU inputs are all 0 in IDLE and RESP cycles.
- Reset in EXEC: pulse Reset during EXEC -> no ack; result=0, flags=0, owner=0; next request is granted to requester 0 first.
